// File: rtl/lcd_frame_ctrl_if.sv
// Pin bundle for a write-only HD44780 LCD on a 4-bit bus.
// The master side (the frame sequencer) is the only driver of these pins.
interface lcd_frame_ctrl_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [3:0] LCD_D;

  modport master (output LCD_E, LCD_RS, LCD_RW, LCD_D);
  modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_D);
endinterface

// File: rtl/lcd_frame_ctrl.sv
// HD44780 16x2 sequencer: power-on init, then repeated streaming of two 16-char row snapshots.
// Optional macro LCD_CHANGE_ONLY_EN: skip rewriting a frame whose rows match the last one written.
module lcd_frame_ctrl #(
  parameter int unsigned T_PWRON = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLEAR = 82000,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EHIGH = 12,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     row_A,
  input  logic [127:0]     row_B,
  output logic             ready,
  output logic             frame_done,
  lcd_frame_ctrl_if.master lcd
);

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_CFG,
    ST_FRAME_START,
    ST_SET_A,
    ST_WR_A,
    ST_SET_B,
    ST_WR_B,
    ST_FRAME_END
`ifdef LCD_CHANGE_ONLY_EN
    , ST_IDLE
`endif
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EHIGH,
    PH_HOLD,
    PH_WAIT
  } phase_e;

  localparam logic [19:0] LD_PWRON = 20'(T_PWRON - 1);
  localparam logic [19:0] LD_INIT1 = 20'(T_INIT1 - 1);
  localparam logic [19:0] LD_INIT2 = 20'(T_INIT2 - 1);
  localparam logic [19:0] LD_CMD   = 20'(T_CMD - 1);
  localparam logic [19:0] LD_CLEAR = 20'(T_CLEAR - 1);
  localparam logic [19:0] LD_NIB   = 20'(T_NIB - 1);
  localparam logic [19:0] LD_SETUP = 20'(T_SETUP - 1);
  localparam logic [19:0] LD_EHIGH = 20'(T_EHIGH - 1);
  localparam logic [19:0] LD_HOLD  = 20'(T_HOLD - 1);

  state_e       state_q, state_d;
  phase_e       phase_q, phase_d;
  logic [19:0]  cnt_q, cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic         nib_lo_q, nib_lo_d;
  logic [127:0] snap_a_q, snap_a_d;
  logic [127:0] snap_b_q, snap_b_d;
`ifdef LCD_CHANGE_ONLY_EN
  logic         snap_vld_q, snap_vld_d;
`endif

  logic         cnt_zero;
  logic         xfer;
  logic         byte_mode;
  logic         last_item;
  logic [7:0]   cur_byte;
  logic [3:0]   cur_nib;
  logic [19:0]  wait_ld;
  state_e       next_section;

  assign cnt_zero = (cnt_q == 20'd0);

  // Decode of what the current transfer slot puts on the bus and how long to wait after it.
  always_comb begin
    xfer         = 1'b0;
    byte_mode    = 1'b1;
    last_item    = 1'b0;
    cur_byte     = 8'h00;
    next_section = ST_FRAME_START;
    case (state_q)
      ST_INIT: begin
        xfer         = 1'b1;
        byte_mode    = 1'b0;
        last_item    = (idx_q == 4'd3);
        next_section = ST_CFG;
      end
      ST_CFG: begin
        xfer         = 1'b1;
        last_item    = (idx_q == 4'd3);
        next_section = ST_FRAME_START;
        case (idx_q[1:0])
          2'd0:    cur_byte = 8'h28;
          2'd1:    cur_byte = 8'h06;
          2'd2:    cur_byte = 8'h0C;
          default: cur_byte = 8'h01;
        endcase
      end
      ST_SET_A: begin
        xfer         = 1'b1;
        last_item    = 1'b1;
        cur_byte     = 8'h80;
        next_section = ST_WR_A;
      end
      ST_WR_A: begin
        xfer         = 1'b1;
        last_item    = (idx_q == 4'd15);
        cur_byte     = snap_a_q[{~idx_q, 3'b000} +: 8];
        next_section = ST_SET_B;
      end
      ST_SET_B: begin
        xfer         = 1'b1;
        last_item    = 1'b1;
        cur_byte     = 8'hC0;
        next_section = ST_WR_B;
      end
      ST_WR_B: begin
        xfer         = 1'b1;
        last_item    = (idx_q == 4'd15);
        cur_byte     = snap_b_q[{~idx_q, 3'b000} +: 8];
        next_section = ST_FRAME_END;
      end
      default: ;
    endcase

    if (!byte_mode) begin
      cur_nib = (idx_q == 4'd3) ? 4'h2 : 4'h3;
    end else begin
      cur_nib = nib_lo_q ? cur_byte[3:0] : cur_byte[7:4];
    end

    // The clear command needs a much longer settle than every other byte.
    if (!byte_mode) begin
      case (idx_q)
        4'd0:    wait_ld = LD_INIT1;
        4'd1:    wait_ld = LD_INIT2;
        default: wait_ld = LD_CMD;
      endcase
    end else if (!nib_lo_q) begin
      wait_ld = LD_NIB;
    end else if (cur_byte == 8'h01) begin
      wait_ld = LD_CLEAR;
    end else begin
      wait_ld = LD_CMD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PWR_WAIT;
      phase_q    <= PH_SETUP;
      cnt_q      <= LD_PWRON;
      idx_q      <= 4'd0;
      nib_lo_q   <= 1'b0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
`ifdef LCD_CHANGE_ONLY_EN
      snap_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      nib_lo_q   <= nib_lo_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
`ifdef LCD_CHANGE_ONLY_EN
      snap_vld_q <= snap_vld_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_zero ? 20'd0 : (cnt_q - 20'd1);
    idx_d      = idx_q;
    nib_lo_d   = nib_lo_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
`ifdef LCD_CHANGE_ONLY_EN
    snap_vld_d = snap_vld_q;
`endif

    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_zero) begin
          state_d  = ST_INIT;
          phase_d  = PH_SETUP;
          cnt_d    = LD_SETUP;
          idx_d    = 4'd0;
          nib_lo_d = 1'b0;
        end
      end

      ST_FRAME_START: begin
`ifdef LCD_CHANGE_ONLY_EN
        if (snap_vld_q && ({row_A, row_B} == {snap_a_q, snap_b_q})) begin
          state_d = ST_IDLE;
        end else begin
          snap_vld_d = 1'b1;
`endif
          // Rows are captured once here so a frame can never mix old and new text.
          snap_a_d = row_A;
          snap_b_d = row_B;
          state_d  = ST_SET_A;
          phase_d  = PH_SETUP;
          cnt_d    = LD_SETUP;
          idx_d    = 4'd0;
          nib_lo_d = 1'b0;
`ifdef LCD_CHANGE_ONLY_EN
        end
`endif
      end

`ifdef LCD_CHANGE_ONLY_EN
      ST_IDLE: begin
        if ({row_A, row_B} != {snap_a_q, snap_b_q}) begin
          state_d = ST_FRAME_START;
        end
      end
`endif

      ST_FRAME_END: begin
        state_d = ST_FRAME_START;
      end

      default: begin
        if (cnt_zero) begin
          case (phase_q)
            PH_SETUP: begin
              phase_d = PH_EHIGH;
              cnt_d   = LD_EHIGH;
            end
            PH_EHIGH: begin
              phase_d = PH_HOLD;
              cnt_d   = LD_HOLD;
            end
            PH_HOLD: begin
              phase_d = PH_WAIT;
              cnt_d   = wait_ld;
            end
            default: begin
              phase_d = PH_SETUP;
              cnt_d   = LD_SETUP;
              if (byte_mode && !nib_lo_q) begin
                nib_lo_d = 1'b1;
              end else begin
                nib_lo_d = 1'b0;
                if (last_item) begin
                  idx_d   = 4'd0;
                  state_d = next_section;
                end else begin
                  idx_d = idx_q + 4'd1;
                end
              end
            end
          endcase
        end
      end
    endcase
  end

  // Pins depend only on registered state, so E falls on the very edge reset is seen.
  always_comb begin
    ready      = !((state_q == ST_PWR_WAIT) || (state_q == ST_INIT) || (state_q == ST_CFG));
    frame_done = (state_q == ST_FRAME_END);
    lcd.LCD_RW = 1'b0;
    lcd.LCD_E  = xfer && (phase_q == PH_EHIGH);
    lcd.LCD_RS = (state_q == ST_WR_A) || (state_q == ST_WR_B);
    lcd.LCD_D  = xfer ? cur_nib : 4'h0;
  end

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Directed bench for lcd_frame_ctrl with shortened wait timings.
// Build with LCD_CHANGE_ONLY_EN defined to exercise the skip-unchanged-frame variant.
module tb_lcd_frame_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] rowA;
  logic [127:0] rowB;
  logic         ready;
  logic         frameDone;

  lcd_frame_ctrl_if lcdBus ();

  lcd_frame_ctrl #(
    .T_PWRON(100), .T_INIT1(40), .T_INIT2(20), .T_CMD(10), .T_CLEAR(30), .T_NIB(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_A      (rowA),
    .row_B      (rowB),
    .ready      (ready),
    .frame_done (frameDone),
    .lcd        (lcdBus)
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int errCount = 0;

  logic [4:0] pulseQ[$];
  int         markQ[$];
  int         stabErr = 0;
  int         widthErr = 0;

  logic [4:0] hist1, hist2, pulseVal, cur;
  logic       prevE = 1'b0;
  int         eWidth = 0;
  int         holdLeft = 0;

  // Pulse recorder: logs {RS,D} at every E rise and polices width, setup and hold.
  always @(negedge clk) begin
    cur = {lcdBus.LCD_RS, lcdBus.LCD_D};
    if (rst) begin
      prevE    = 1'b0;
      eWidth   = 0;
      holdLeft = 0;
      hist1    = cur;
      hist2    = cur;
    end else begin
      if (lcdBus.LCD_E && !prevE) begin
        pulseQ.push_back(cur);
        if (hist1 !== cur || hist2 !== cur) stabErr++;
        pulseVal = cur;
        eWidth   = 1;
      end else if (lcdBus.LCD_E) begin
        eWidth++;
        if (cur !== pulseVal) stabErr++;
      end else if (prevE) begin
        if (eWidth != 12) widthErr++;
        if (cur !== pulseVal) stabErr++;
        holdLeft = 1;
      end else if (holdLeft > 0) begin
        if (cur !== pulseVal) stabErr++;
        holdLeft--;
      end
      if (frameDone) markQ.push_back(pulseQ.size());
      prevE = lcdBus.LCD_E;
      hist2 = hist1;
      hist1 = cur;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vecCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b);
    rowA = a;
    rowB = b;
  endtask

  task automatic waitPulses(input string tag, input int n, input int budget);
    int c = 0;
    while (pulseQ.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    checkOutput(tag, int'(pulseQ.size() >= n), 1);
  endtask

  task automatic waitFrames(input string tag, input int n, input int budget);
    int c = 0;
    while (markQ.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    checkOutput(tag, int'(markQ.size() >= n), 1);
  endtask

  // Expected {RS,D} for pulse p (0..67) of a frame built from rows a/b.
  function automatic logic [4:0] expPulse(input int p, input logic [127:0] a, input logic [127:0] b);
    logic [7:0] by;
    logic       rs;
    if (p < 2) begin
      by = 8'h80; rs = 1'b0;
    end else if (p < 34) begin
      by = a[127 - 8*((p-2)/2) -: 8]; rs = 1'b1;
    end else if (p < 36) begin
      by = 8'hC0; rs = 1'b0;
    end else begin
      by = b[127 - 8*((p-36)/2) -: 8]; rs = 1'b1;
    end
    return {rs, (p % 2 == 0) ? by[7:4] : by[3:0]};
  endfunction

  task automatic checkInitSequence(input string tag);
    logic [4:0] initExp[12];
    initExp = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("%s_p%0d", tag, i), int'(pulseQ[i]), int'(initExp[i]));
    end
  endtask

  task automatic checkFrame(input string tag, input int base, input logic [127:0] a, input logic [127:0] b);
    for (int p = 0; p < 68; p++) begin
      checkOutput($sformatf("%s_p%0d", tag, p), int'(pulseQ[base + p]), int'(expPulse(p, a, b)));
    end
  endtask

  task automatic waitReady(input string tag);
    int c = 0;
    while (!ready && c < 500) begin
      @(negedge clk);
      #1;
      c++;
    end
    checkOutput(tag, int'(ready), 1);
  endtask

  logic [127:0] rowA0, rowB0, rowA1, rowB1;

  initial begin
    rowA0 = "Hello, World!   ";
    rowB0 = "0123456789ABCDEF";
    rowA1 = "Jello, World!   ";
    rowB1 = "0123456789ABCDEG";
    applyStimulus(rowA0, rowB0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;

    // Reset state
    checkOutput("rst_E", int'(lcdBus.LCD_E), 0);
    checkOutput("rst_RS", int'(lcdBus.LCD_RS), 0);
    checkOutput("rst_RW", int'(lcdBus.LCD_RW), 0);
    checkOutput("rst_D", int'(lcdBus.LCD_D), 0);
    checkOutput("rst_ready", int'(ready), 0);
    checkOutput("rst_frame_done", int'(frameDone), 0);
    rst = 1'b0;

    // Power-on wait, then init and configuration nibbles
    repeat (100) @(negedge clk);
    #1;
    checkOutput("pwron_quiet", pulseQ.size(), 0);
    checkOutput("pwron_not_ready", int'(ready), 0);
    waitPulses("init_pulses", 12, 2000);
    checkInitSequence("init");
    checkOutput("ready_low_during_clear", int'(ready), 0);
    waitReady("ready_up");

    // First frame content
    waitPulses("frame0_pulses", 80, 4000);
    checkOutput("f0_setA_hi", int'(pulseQ[12]), 5'h08);
    checkOutput("f0_setA_lo", int'(pulseQ[13]), 5'h00);
    checkOutput("f0_H_hi", int'(pulseQ[14]), 5'h14);
    checkOutput("f0_H_lo", int'(pulseQ[15]), 5'h18);
    checkOutput("f0_e_hi", int'(pulseQ[16]), 5'h16);
    checkOutput("f0_e_lo", int'(pulseQ[17]), 5'h15);
    checkOutput("f0_setB_hi", int'(pulseQ[46]), 5'h0C);
    checkOutput("f0_setB_lo", int'(pulseQ[47]), 5'h00);
    checkOutput("f0_0_hi", int'(pulseQ[48]), 5'h13);
    checkOutput("f0_0_lo", int'(pulseQ[49]), 5'h10);
    checkFrame("f0", 12, rowA0, rowB0);
    waitFrames("frame0_done", 1, 500);
    checkOutput("frame0_mark", markQ[0], 80);

`ifdef LCD_CHANGE_ONLY_EN
    // Unchanged rows: no further traffic
    repeat (10000) @(negedge clk);
    #1;
    checkOutput("idle_no_pulses", pulseQ.size(), 80);
    checkOutput("idle_no_frames", markQ.size(), 1);
    checkOutput("idle_E_low", int'(lcdBus.LCD_E), 0);
    applyStimulus(rowA0, rowB1);
    waitFrames("changed_frame_done", 2, 4000);
    checkOutput("changed_frame_len", markQ[1] - markQ[0], 68);
    checkFrame("f1", 80, rowA0, rowB1);
    repeat (3000) @(negedge clk);
    #1;
    checkOutput("idle_again_frames", markQ.size(), 2);
    checkOutput("idle_again_pulses", pulseQ.size(), 148);
`else
    // Back-to-back frames of exactly 68 pulses
    waitFrames("frame1_done", 2, 4000);
    checkOutput("frame1_len", markQ[1] - markQ[0], 68);
    checkFrame("f1", 80, rowA0, rowB0);

    // Row change during WR_B must not tear the frame in flight
    waitPulses("frame2_wrb", 148 + 40, 4000);
    applyStimulus(rowA1, rowB0);
    waitFrames("frame2_done", 3, 4000);
    checkOutput("frame2_len", markQ[2] - markQ[1], 68);
    checkFrame("f2", 148, rowA0, rowB0);
    waitPulses("frame3_pulses", 216 + 68, 4000);
    checkOutput("f3_J_hi", int'(pulseQ[218]), 5'h14);
    checkOutput("f3_J_lo", int'(pulseQ[219]), 5'h1A);
    checkFrame("f3", 216, rowA1, rowB0);

    // Reset mid-pulse at char 7 of WR_A
    waitPulses("frame4_char7", 284 + 17, 4000);
    checkOutput("f4_char7_hi", int'(pulseQ[300]), int'(expPulse(16, rowA1, rowB0)));
    checkOutput("mid_E_high", int'(lcdBus.LCD_E), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_E", int'(lcdBus.LCD_E), 0);
    checkOutput("mid_rst_ready", int'(ready), 0);
    repeat (4) @(negedge clk);
    pulseQ.delete();
    markQ.delete();
    rst = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    checkOutput("rerun_pwron_quiet", pulseQ.size(), 0);
    waitPulses("rerun_init_pulses", 12, 2000);
    checkInitSequence("rerun_init");
    waitReady("rerun_ready_up");
    waitPulses("rerun_frame_pulses", 80, 4000);
    checkFrame("rerun_f0", 12, rowA1, rowB0);
`endif

    checkOutput("e_width_errors", widthErr, 0);
    checkOutput("setup_hold_errors", stabErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
